// File: rtl/wb_shared_ram_arbiter.sv
// Round-robin arbiter placing per-CPU data and fetch ports onto one single-port RAM.
// One access in flight at a time: IDLE -> ISSUE -> READ -> ACK, four cycles per access.
module wb_shared_ram_arbiter #(
  parameter int NUM_CPU = 4,
  parameter int AW      = 14,
  parameter int DW      = 32,
  localparam int NS     = 2 * NUM_CPU,
  localparam int SW     = $clog2(NS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_CPU-1:0]    dat_cyc_i,
  input  logic [NUM_CPU-1:0]    dat_we_i,
  input  logic [NUM_CPU*DW-1:0] dat_adr_i,
  input  logic [NUM_CPU*DW-1:0] dat_wdat_i,
  output logic [NUM_CPU-1:0]    dat_ack_o,
  input  logic [NUM_CPU-1:0]    inst_cyc_i,
  input  logic [NUM_CPU*16-1:0] inst_pc_i,
  output logic [NUM_CPU-1:0]    inst_ack_o,
  output logic [DW-1:0]         rdat_o,
  output logic                  ram_en_o,
  output logic                  ram_we_o,
  output logic [AW-1:0]         ram_adr_o,
  output logic [DW-1:0]         ram_wdat_o,
  input  logic [DW-1:0]         ram_rdat_i,
  output logic [1:0]            dbg_state_o,   // 0=IDLE 1=ISSUE 2=READ 3=ACK
  output logic [SW-1:0]         dbg_rr_ptr_o
);

  // Handshake: a slot's cyc is a level request sampled only in IDLE; the grant is
  // answered by exactly one single-cycle ack, after which the requester drops cyc.
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_READ, S_ACK} state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] rr_ptr_q, rr_ptr_d;
  logic [SW-1:0] slot_q, slot_d;
  logic [NS-1:0] ack_q, ack_d;
  logic          ram_en_q, ram_en_d;
  logic          ram_we_q, ram_we_d;
  logic [AW-1:0] adr_q, adr_d;
  logic [DW-1:0] wdat_q, wdat_d;
  logic [DW-1:0] rdat_q, rdat_d;
  logic [NS-1:0] req;
  logic          found;
  logic [SW-1:0] win;
  int            win_cpu;

  always_comb begin
    req = '0;
    for (int k = 0; k < NUM_CPU; k++) begin
      req[2*k]   = dat_cyc_i[k];
      req[2*k+1] = inst_cyc_i[k];
    end
  end

  // First active slot at or after rr_ptr, wrapping around.
  always_comb begin : win_scan
    int idx;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int i = 0; i < NS; i++) begin
      idx = (int'(rr_ptr_q) + i) % NS;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = SW'(idx);
      end
    end
    win_cpu = int'(win) / 2;
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    slot_d   = slot_q;
    ack_d    = '0;
    ram_en_d = 1'b0;
    ram_we_d = 1'b0;
    adr_d    = adr_q;
    wdat_d   = wdat_q;
    rdat_d   = rdat_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          slot_d   = win;
          rr_ptr_d = (win == SW'(NS - 1)) ? '0 : win + 1'b1;
          ram_en_d = 1'b1;
          if (win[0]) begin
            ram_we_d = 1'b0;
            adr_d    = inst_pc_i[win_cpu*16 +: AW];
            wdat_d   = '0;
          end else begin
            ram_we_d = dat_we_i[win_cpu];
            adr_d    = dat_adr_i[win_cpu*DW +: AW];
            wdat_d   = dat_wdat_i[win_cpu*DW +: DW];
          end
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_READ;
      S_READ: begin
        rdat_d        = ram_rdat_i;
        ack_d[slot_q] = 1'b1;
        state_d       = S_ACK;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      slot_q   <= '0;
      ack_q    <= '0;
      ram_en_q <= 1'b0;
      ram_we_q <= 1'b0;
      adr_q    <= '0;
      wdat_q   <= '0;
      rdat_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      slot_q   <= slot_d;
      ack_q    <= ack_d;
      ram_en_q <= ram_en_d;
      ram_we_q <= ram_we_d;
      adr_q    <= adr_d;
      wdat_q   <= wdat_d;
      rdat_q   <= rdat_d;
    end
  end

  always_comb begin
    dat_ack_o  = '0;
    inst_ack_o = '0;
    for (int k = 0; k < NUM_CPU; k++) begin
      dat_ack_o[k]  = ack_q[2*k];
      inst_ack_o[k] = ack_q[2*k+1];
    end
  end

  // The strobe is masked by reset so an aborted ISSUE cycle never writes the RAM.
  assign ram_en_o     = ram_en_q & ~rst;
  assign ram_we_o     = ram_we_q & ~rst;
  assign ram_adr_o    = adr_q;
  assign ram_wdat_o   = wdat_q;
  assign rdat_o       = rdat_q;
  assign dbg_state_o  = state_q;
  assign dbg_rr_ptr_o = rr_ptr_q;

endmodule

// File: tb/tb_wb_shared_ram_arbiter.sv
// Bench for wb_shared_ram_arbiter: directed scenarios plus randomized requesters,
// checked every cycle against a transaction-level round-robin reference model.
module tb_wb_shared_ram_arbiter;
  localparam int NUM_CPU = 4;
  localparam int AW      = 14;
  localparam int DW      = 32;
  localparam int NS      = 2 * NUM_CPU;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT connections ----------------
  logic [NUM_CPU-1:0]    dcyc, dwe, icyc;
  logic [DW-1:0]         dadr [NUM_CPU];
  logic [DW-1:0]         dwdat[NUM_CPU];
  logic [15:0]           ipc  [NUM_CPU];
  logic [NUM_CPU*DW-1:0] dat_adr_i, dat_wdat_i;
  logic [NUM_CPU*16-1:0] inst_pc_i;
  logic [NUM_CPU-1:0]    dat_ack_o, inst_ack_o;
  logic [DW-1:0]         rdat_o, ram_wdat_o, ram_rdat_i;
  logic                  ram_en_o, ram_we_o;
  logic [AW-1:0]         ram_adr_o;
  logic [1:0]            dbg_state_o;
  logic [2:0]            dbg_rr_ptr_o;
  logic [NS-1:0]         ack_vec;

  always_comb begin
    for (int k = 0; k < NUM_CPU; k++) begin
      dat_adr_i[k*DW +: DW]  = dadr[k];
      dat_wdat_i[k*DW +: DW] = dwdat[k];
      inst_pc_i[k*16 +: 16]  = ipc[k];
      ack_vec[2*k]           = dat_ack_o[k];
      ack_vec[2*k+1]         = inst_ack_o[k];
    end
  end

  wb_shared_ram_arbiter #(.NUM_CPU(NUM_CPU), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .dat_cyc_i(dcyc), .dat_we_i(dwe), .dat_adr_i(dat_adr_i), .dat_wdat_i(dat_wdat_i),
    .dat_ack_o(dat_ack_o),
    .inst_cyc_i(icyc), .inst_pc_i(inst_pc_i), .inst_ack_o(inst_ack_o),
    .rdat_o(rdat_o), .ram_en_o(ram_en_o), .ram_we_o(ram_we_o), .ram_adr_o(ram_adr_o),
    .ram_wdat_o(ram_wdat_o), .ram_rdat_i(ram_rdat_i),
    .dbg_state_o(dbg_state_o), .dbg_rr_ptr_o(dbg_rr_ptr_o)
  );

  function automatic logic [DW-1:0] init_word(int a);
    if (a == 32'h1005) return 32'h6000_0023;
    return (DW'(a) * 32'h9E37_79B1) ^ 32'h0F1E_2D3C;
  endfunction

  // ---------------- RAM model (single port, registered read) ----------------
  logic [DW-1:0] mem [0:(1<<AW)-1];
  initial begin : ram_model
    for (int a = 0; a < (1 << AW); a++) mem[a] = init_word(a);
    ram_rdat_i = '0;
    forever begin
      @(posedge clk);
      if (ram_en_o) begin
        if (ram_we_o) mem[ram_adr_o] <= ram_wdat_o;
        ram_rdat_i <= mem[ram_adr_o];
      end
    end
  end

  // ---------------- scoreboard counters and check task ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit slot_req(int s);
    return (s % 2 == 0) ? dcyc[s/2] : icyc[s/2];
  endfunction

  // ---------------- reference model: grant schedule by edge number ----------------
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  int            m_edge = 0;
  int            m_next_free = 0;
  int            m_ptr = 0;
  bit            m_gv = 1'b0;
  int            m_g = 0;
  int            m_slot = 0;
  bit            m_we = 1'b0;
  logic [AW-1:0] m_adr = '0;
  logic [DW-1:0] m_wdat = '0;
  int            grant_log[$];

  initial begin : ref_model
    for (int a = 0; a < (1 << AW); a++) ref_mem[a] = init_word(a);
    forever begin
      @(posedge clk);
      if (rst) begin
        m_gv        = 1'b0;
        m_ptr       = 0;
        m_next_free = m_edge + 1;
      end else begin
        if (m_gv && m_edge == m_g + 1 && m_we) ref_mem[m_adr] = m_wdat;
        if (m_edge >= m_next_free) begin : arbitrate
          int win;
          win = -1;
          for (int i = 0; i < NS; i++) begin
            int s;
            s = (m_ptr + i) % NS;
            if (win < 0 && slot_req(s)) win = s;
          end
          if (win >= 0) begin
            m_gv        = 1'b1;
            m_g         = m_edge;
            m_slot      = win;
            m_ptr       = (win + 1) % NS;
            m_next_free = m_edge + 4;
            if (win % 2 == 0) begin
              m_we   = dwe[win/2];
              m_adr  = dadr[win/2][AW-1:0];
              m_wdat = dwdat[win/2];
            end else begin
              m_we   = 1'b0;
              m_adr  = ipc[win/2][AW-1:0];
              m_wdat = '0;
            end
            grant_log.push_back(win);
          end
        end
      end
      m_edge++;
    end
  end

  // Per-cycle comparison of the RAM port and acks against the model schedule.
  bit chk_en = 1'b0;
  always @(negedge clk) begin
    if (chk_en) begin : cycle_check
      int d;
      logic [NS-1:0] eack;
      d    = m_gv ? (m_edge - 1 - m_g) : -1;
      eack = '0;
      if (d == 2) eack[m_slot] = 1'b1;
      check_eq("ram_en", ram_en_o, (d == 0) && !rst);
      check_eq("acks", ack_vec, eack);
      if (d == 0 && !rst) begin
        check_eq("ram_adr", ram_adr_o, m_adr);
        check_eq("ram_we", ram_we_o, m_we);
        if (m_we) check_eq("ram_wdat", ram_wdat_o, m_wdat);
      end
      if (d == 2 && !m_we) check_eq("rdat", rdat_o, ref_mem[m_adr]);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_req(input int s, input bit v);
    if (s % 2 == 0) dcyc[s/2] = v;
    else            icyc[s/2] = v;
  endtask

  task automatic clear_reqs();
    dcyc = '0; dwe = '0; icyc = '0;
    for (int k = 0; k < NUM_CPU; k++) begin
      dadr[k] = '0; dwdat[k] = '0; ipc[k] = '0;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    clear_reqs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic randomize_slot(input int s);
    int k;
    k = s / 2;
    if (s % 2 == 0) begin
      dwe[k]           = 1'($urandom_range(0, 1));
      dadr[k]          = $urandom;
      dadr[k][AW-1:0]  = AW'($urandom_range(0, 31));
      dwdat[k]         = $urandom;
    end else begin
      ipc[k]           = 16'($urandom);
      ipc[k][AW-1:0]   = AW'($urandom_range(0, 63));
    end
  endtask

  // Waits for the next ack (bounded); drops the acked request unless hold is set.
  task automatic next_ack(input bit hold, output int slot, output int waited);
    slot   = -1;
    waited = 0;
    for (int c = 0; c < 30 && slot < 0; c++) begin
      @(posedge clk); #1;
      waited++;
      for (int s = 0; s < NS; s++) if (ack_vec[s] && slot < 0) slot = s;
    end
    check_eq("ack_arrived", (slot >= 0), 1);
    if (slot >= 0 && !hold) set_req(slot, 1'b0);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin : main
    int slot, waited, cnt;
    clear_reqs();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;

    check_eq("rst_dat_ack", dat_ack_o, 0);
    check_eq("rst_inst_ack", inst_ack_o, 0);
    check_eq("rst_rdat", rdat_o, 0);
    check_eq("rst_ram_en", ram_en_o, 0);
    check_eq("rst_ram_we", ram_we_o, 0);
    check_eq("rst_ram_adr", ram_adr_o, 0);
    check_eq("rst_ram_wdat", ram_wdat_o, 0);
    check_eq("rst_rr_ptr", dbg_rr_ptr_o, 0);
    check_eq("rst_state", dbg_state_o, 0);

    // Single fetch from CPU1.
    ipc[1]  = 16'h1005;
    icyc[1] = 1'b1;
    next_ack(1'b0, slot, waited);
    check_eq("fetch_slot", slot, 3);
    check_eq("fetch_inst_ack", inst_ack_o, 4'b0010);
    check_eq("fetch_rdat", rdat_o, 32'h6000_0023);

    // CPU0 write then read back.
    dadr[0] = 32'hABCD_2000; dwdat[0] = 32'hDEAD_BEEF; dwe[0] = 1'b1; dcyc[0] = 1'b1;
    next_ack(1'b0, slot, waited);
    check_eq("wr_slot", slot, 0);
    dadr[0] = 32'h0000_2000; dwe[0] = 1'b0; dcyc[0] = 1'b1;
    next_ack(1'b0, slot, waited);
    check_eq("rd_slot", slot, 0);
    check_eq("rd_dat_ack", dat_ack_o, 4'b0001);
    check_eq("rd_rdat", rdat_o, 32'hDEAD_BEEF);

    // Fairness: every slot held high from reset.
    @(posedge clk); #1;
    rst = 1'b1;
    clear_reqs();
    for (int s = 0; s < NS; s++) begin
      randomize_slot(s);
      if (s % 2 == 0) dwe[s/2] = 1'b0;
      set_req(s, 1'b1);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < NS + 1; i++) begin
      next_ack(1'b1, slot, waited);
      check_eq("rr_order", slot, i % NS);
      if (i > 0) check_eq("rr_spacing", waited, 4);
    end
    clear_reqs();

    // Same-CPU contention with rr_ptr at 0.
    do_reset();
    dadr[2] = 32'h0000_0010; ipc[2] = 16'h0020;
    dcyc[2] = 1'b1; icyc[2] = 1'b1;
    next_ack(1'b0, slot, waited);
    check_eq("same_cpu_first", slot, 4);
    next_ack(1'b0, slot, waited);
    check_eq("same_cpu_second", slot, 5);
    check_eq("same_cpu_spacing", waited, 4);

    // Reset during the ISSUE cycle of a CPU3 write.
    repeat (4) @(posedge clk);
    #1;
    dadr[3] = 32'h0000_0123; dwdat[3] = 32'hA5A5_0F0F; dwe[3] = 1'b1; dcyc[3] = 1'b1;
    cnt = 0;
    for (int c = 0; c < 10 && dbg_state_o != 2'd1; c++) begin
      @(posedge clk); #1;
    end
    check_eq("mid_rst_issue_reached", dbg_state_o, 2'd1);
    rst = 1'b1;
    dcyc[3] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("mid_rst_acks", ack_vec, 0);
    check_eq("mid_rst_ram_en", ram_en_o, 0);
    check_eq("mid_rst_ram_we", ram_we_o, 0);
    check_eq("mid_rst_ram_adr", ram_adr_o, 0);
    check_eq("mid_rst_ram_wdat", ram_wdat_o, 0);
    check_eq("mid_rst_rdat", rdat_o, 0);
    check_eq("mid_rst_rr_ptr", dbg_rr_ptr_o, 0);
    repeat (6) begin
      @(posedge clk); #1;
      if (|ack_vec) cnt++;
    end
    check_eq("mid_rst_no_ack", cnt, 0);
    check_eq("mid_rst_mem", mem[14'h0123], init_word(32'h123));

    // Idle bus.
    cnt = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (ram_en_o || (|ack_vec)) cnt++;
    end
    check_eq("idle_quiet", cnt, 0);

    // Randomized requesters with occasional withdrawal.
    repeat (1500) begin
      @(posedge clk); #1;
      for (int s = 0; s < NS; s++) begin
        if (ack_vec[s]) set_req(s, 1'b0);
        else if (slot_req(s)) begin
          if ($urandom_range(0, 31) == 0) set_req(s, 1'b0);
        end else if ($urandom_range(0, 3) == 0) begin
          randomize_slot(s);
          set_req(s, 1'b1);
        end
      end
    end
    clear_reqs();
    repeat (8) @(posedge clk);
    check_eq("grants_made", (grant_log.size() > 100), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
